// File: rtl/wfg_stim_sweep.sv
// Frequency-sweep sequencer for the CORDIC sine stimulus: steps the angular
// increment between start and stop after a programmed number of accepted samples.
module wfg_stim_sweep (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en_i,
    input  logic [1:0]  cfg_mode_i,
    input  logic [15:0] cfg_start_inc_i,
    input  logic [15:0] cfg_stop_inc_i,
    input  logic [15:0] cfg_step_i,
    input  logic [15:0] cfg_dwell_i,
    input  logic        sample_valid_i,
    input  logic        sample_ready_i,
    output logic        stim_en_o,
    output logic [15:0] stim_inc_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

    localparam logic [1:0] MODE_REPEAT   = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;

    state_t      state_q, state_d;
    logic [15:0] inc_q, inc_d;
    logic [15:0] dwell_cnt_q, dwell_cnt_d;
    logic [15:0] start_q, start_d;
    logic [15:0] stop_q, stop_d;
    logic [15:0] step_q, step_d;
    logic [15:0] dwell_q, dwell_d;
    logic [1:0]  mode_q, mode_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        hs;
    logic        degenerate;
    logic [15:0] last_cnt;
    logic [16:0] up_sum, dn_diff, tri_diff, tri_sum;
    logic [15:0] up_next, dn_next, tri_down_next, tri_up_next;

    // Clamped candidates for every kind of step; 17-bit math catches carry/borrow.
    always_comb begin
        hs         = sample_valid_i & sample_ready_i;
        degenerate = start_q > stop_q;
        last_cnt   = (dwell_q == 16'd0) ? 16'd0 : dwell_q - 16'd1;

        up_sum   = {1'b0, inc_q} + {1'b0, step_q};
        dn_diff  = {1'b0, inc_q} - {1'b0, step_q};
        tri_diff = {1'b0, stop_q} - {1'b0, step_q};
        tri_sum  = {1'b0, start_q} + {1'b0, step_q};

        up_next       = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[15:0];
        dn_next       = (dn_diff[16] || (dn_diff[15:0] < start_q)) ? start_q : dn_diff[15:0];
        tri_down_next = (tri_diff[16] || (tri_diff[15:0] < start_q)) ? start_q : tri_diff[15:0];
        tri_up_next   = (tri_sum > {1'b0, stop_q}) ? stop_q : tri_sum[15:0];
    end

    // Next-state logic; a disable in UP/DOWN always wins over a pending step.
    always_comb begin
        state_d     = state_q;
        inc_d       = inc_q;
        dwell_cnt_d = dwell_cnt_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        mode_d      = mode_q;

        case (state_q)
            IDLE: begin
                if (cfg_en_i) begin
                    start_d     = cfg_start_inc_i;
                    stop_d      = cfg_stop_inc_i;
                    step_d      = cfg_step_i;
                    dwell_d     = cfg_dwell_i;
                    mode_d      = cfg_mode_i;
                    inc_d       = cfg_start_inc_i;
                    dwell_cnt_d = 16'd0;
                    state_d     = UP;
                end
            end
            UP: begin
                if (!cfg_en_i) begin
                    state_d     = IDLE;
                    dwell_cnt_d = 16'd0;
                end else if (hs) begin
                    if (dwell_cnt_q < last_cnt) begin
                        dwell_cnt_d = dwell_cnt_q + 16'd1;
                    end else begin
                        dwell_cnt_d = 16'd0;
                        if (inc_q >= stop_q) begin
                            if (mode_q == MODE_REPEAT) begin
                                inc_d = start_q;
                            end else if (mode_q == MODE_TRIANGLE) begin
                                state_d = DOWN;
                                inc_d   = degenerate ? start_q : tri_down_next;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            inc_d = up_next;
                        end
                    end
                end
            end
            DOWN: begin
                if (!cfg_en_i) begin
                    state_d     = IDLE;
                    dwell_cnt_d = 16'd0;
                end else if (hs) begin
                    if (dwell_cnt_q < last_cnt) begin
                        dwell_cnt_d = dwell_cnt_q + 16'd1;
                    end else begin
                        dwell_cnt_d = 16'd0;
                        if (inc_q <= start_q) begin
                            state_d = UP;
                            inc_d   = degenerate ? start_q : tri_up_next;
                        end else begin
                            inc_d = dn_next;
                        end
                    end
                end
            end
            DONE: begin
                if (!cfg_en_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        en_d   = (state_d == UP) || (state_d == DOWN);
        busy_d = en_d;
        done_d = (state_q == UP) && (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            inc_q       <= 16'd0;
            dwell_cnt_q <= 16'd0;
            start_q     <= 16'd0;
            stop_q      <= 16'd0;
            step_q      <= 16'd0;
            dwell_q     <= 16'd0;
            mode_q      <= 2'b00;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            inc_q       <= inc_d;
            dwell_cnt_q <= dwell_cnt_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign stim_en_o  = en_q;
    assign stim_inc_o = inc_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_wfg_stim_sweep.sv
// Scoreboard bench for wfg_stim_sweep: stimulus queues the increment expected on
// each accepted sample, a negedge monitor pops and compares on every handshake.
module tb_wfg_stim_sweep;

    logic        clk;
    logic        rst_n;
    logic        cfg_en_i;
    logic [1:0]  cfg_mode_i;
    logic [15:0] cfg_start_inc_i;
    logic [15:0] cfg_stop_inc_i;
    logic [15:0] cfg_step_i;
    logic [15:0] cfg_dwell_i;
    logic        sample_valid_i;
    logic        sample_ready_i;
    logic        stim_en_o;
    logic [15:0] stim_inc_o;
    logic        busy_o;
    logic        done_o;

    int          compared;
    int          mismatched;
    int          doneCount;
    int          sampleIdx;
    logic [15:0] expQ[$];

    wfg_stim_sweep dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_en_i        (cfg_en_i),
        .cfg_mode_i      (cfg_mode_i),
        .cfg_start_inc_i (cfg_start_inc_i),
        .cfg_stop_inc_i  (cfg_stop_inc_i),
        .cfg_step_i      (cfg_step_i),
        .cfg_dwell_i     (cfg_dwell_i),
        .sample_valid_i  (sample_valid_i),
        .sample_ready_i  (sample_ready_i),
        .stim_en_o       (stim_en_o),
        .stim_inc_o      (stim_inc_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Monitor: every accepted sample while the core is enabled consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) doneCount++;
        if (rst_n && stim_en_o && sample_valid_i && sample_ready_i) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL sample%0d: got inc %0d, expected no sample", sampleIdx, stim_inc_o);
            end else begin
                logic [15:0] exp;
                exp = expQ.pop_front();
                if (stim_inc_o !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL sample%0d: got inc %0d, expected %0d", sampleIdx, stim_inc_o, exp);
                end
            end
            sampleIdx++;
        end
    end

    task automatic applyStimulus(input logic valid, input logic ready, input int cycles);
        sample_valid_i = valid;
        sample_ready_i = ready;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic startSweep(input logic [1:0] mode, input logic [15:0] start,
                              input logic [15:0] stop, input logic [15:0] step,
                              input logic [15:0] dwell);
        cfg_mode_i      = mode;
        cfg_start_inc_i = start;
        cfg_stop_inc_i  = stop;
        cfg_step_i      = step;
        cfg_dwell_i     = dwell;
        cfg_en_i        = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
    endtask

    task automatic stopSweep();
        cfg_en_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 2);
    endtask

    task automatic pushList(input int vals[]);
        foreach (vals[i]) expQ.push_back(vals[i][15:0]);
    endtask

    initial begin
        automatic int d0;
        compared = 0; mismatched = 0; doneCount = 0; sampleIdx = 0;
        rst_n = 1'b0; cfg_en_i = 1'b0; cfg_mode_i = 2'b00;
        cfg_start_inc_i = 16'd0; cfg_stop_inc_i = 16'd0;
        cfg_step_i = 16'd0; cfg_dwell_i = 16'd0;
        sample_valid_i = 1'b0; sample_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_en", stim_en_o, 0);
        checkOutput("rst_inc", stim_inc_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);

        $display("[TB] single sweep 100..400 step 100 dwell 2");
        pushList('{100, 100, 200, 200, 300, 300, 400, 400});
        startSweep(2'b00, 16'd100, 16'd400, 16'd100, 16'd2);
        checkOutput("single_start_en", stim_en_o, 1);
        checkOutput("single_start_busy", busy_o, 1);
        d0 = doneCount;
        applyStimulus(1'b1, 1'b1, 8);
        checkOutput("single_done_pulse", done_o, 1);
        checkOutput("single_done_en", stim_en_o, 0);
        checkOutput("single_done_busy", busy_o, 0);
        checkOutput("single_done_inc", stim_inc_o, 400);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("single_done_once", doneCount - d0, 1);
        checkOutput("single_no_restart", stim_en_o, 0);
        checkOutput("single_hold_inc", stim_inc_o, 400);
        checkOutput("single_queue", expQ.size(), 0);
        stopSweep();

        $display("[TB] clamp sweeps");
        pushList('{0, 100, 200, 250});
        startSweep(2'b00, 16'd0, 16'd250, 16'd100, 16'd1);
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput("clamp_done", done_o, 1);
        checkOutput("clamp_inc", stim_inc_o, 250);
        stopSweep();
        pushList('{16'hFF00, 16'hFFF0});
        startSweep(2'b11, 16'hFF00, 16'hFFF0, 16'h0200, 16'd1);
        applyStimulus(1'b1, 1'b1, 2);
        checkOutput("carry_done", done_o, 1);
        checkOutput("carry_inc", stim_inc_o, 16'hFFF0);
        checkOutput("clamp_queue", expQ.size(), 0);
        stopSweep();

        $display("[TB] triangle sweep 10..30 step 10");
        d0 = doneCount;
        pushList('{10, 20, 30, 20, 10, 20, 30, 20, 10, 20});
        startSweep(2'b10, 16'd10, 16'd30, 16'd10, 16'd1);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("tri_busy", busy_o, 1);
        checkOutput("tri_en", stim_en_o, 1);
        checkOutput("tri_no_done", doneCount - d0, 0);
        checkOutput("tri_queue", expQ.size(), 0);
        stopSweep();

        $display("[TB] repeat sweep with backpressure");
        d0 = doneCount;
        pushList('{5, 5, 5, 10, 10, 10, 15, 15, 15, 5, 5});
        startSweep(2'b01, 16'd5, 16'd15, 16'd5, 16'd3);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("stall_inc", stim_inc_o, 5);
        applyStimulus(1'b1, 1'b1, 9);
        checkOutput("rep_no_done", doneCount - d0, 0);
        checkOutput("rep_queue", expQ.size(), 0);
        stopSweep();

        $display("[TB] dwell 0 and step 0");
        d0 = doneCount;
        pushList('{3, 3, 3, 3, 3, 3});
        startSweep(2'b00, 16'd3, 16'd9, 16'd0, 16'd0);
        applyStimulus(1'b1, 1'b1, 6);
        checkOutput("step0_busy", busy_o, 1);
        checkOutput("step0_no_done", doneCount - d0, 0);
        stopSweep();
        pushList('{7});
        startSweep(2'b00, 16'd7, 16'd7, 16'd0, 16'd0);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("eq_done", done_o, 1);
        checkOutput("eq_inc", stim_inc_o, 7);
        checkOutput("step0_queue", expQ.size(), 0);
        stopSweep();

        $display("[TB] abort on a handshake cycle");
        d0 = doneCount;
        pushList('{100, 200, 300});
        startSweep(2'b00, 16'd100, 16'd400, 16'd100, 16'd1);
        applyStimulus(1'b1, 1'b1, 2);
        cfg_en_i = 1'b0;
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("abort_en", stim_en_o, 0);
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_no_step", stim_inc_o, 300);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("abort_no_done", doneCount - d0, 0);
        checkOutput("abort_queue", expQ.size(), 0);

        $display("[TB] config change during sweep, then restart");
        pushList('{100, 200, 300, 400});
        startSweep(2'b00, 16'd100, 16'd400, 16'd100, 16'd1);
        applyStimulus(1'b1, 1'b1, 1);
        cfg_mode_i = 2'b01; cfg_start_inc_i = 16'd1000;
        cfg_stop_inc_i = 16'd2000; cfg_step_i = 16'd1; cfg_dwell_i = 16'd5;
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("cfgchg_done", done_o, 1);
        checkOutput("cfgchg_inc", stim_inc_o, 400);
        stopSweep();
        cfg_en_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("restart_inc", stim_inc_o, 1000);
        checkOutput("restart_en", stim_en_o, 1);
        stopSweep();

        $display("[TB] reset mid-sweep");
        pushList('{100, 200});
        startSweep(2'b10, 16'd100, 16'd400, 16'd100, 16'd1);
        applyStimulus(1'b1, 1'b1, 2);
        sample_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_en", stim_en_o, 0);
        checkOutput("midrst_inc", stim_inc_o, 0);
        checkOutput("midrst_busy", busy_o, 0);
        checkOutput("midrst_done", done_o, 0);
        cfg_en_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("postrst_idle", stim_en_o, 0);
        checkOutput("postrst_inc", stim_inc_o, 0);
        checkOutput("final_queue", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wfg_stim_sweep.md
# wfg_stim_sweep

Frequency-sweep sequencer for the sine stimulus. It drives the CORDIC sine generator's enable and angular-increment inputs. It watches the generator's AXI-stream output handshake and steps the increment from a start value to a stop value after a programmed number of accepted samples per step. It supports single-shot, sawtooth-repeat and triangle (up/down) sweeps, and sits between the register file and the sine stimulus core.

## Interface
- No parameters; all widths are fixed at 16 bits to match the sine core's increment input.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_en_i  in  1  sweep enable; level-sensitive.
- cfg_mode_i  in  2  sweep mode: 00 single, 01 repeat (sawtooth), 10 triangle, 11 treated as single.
- cfg_start_inc_i  in  16  first increment of the sweep.
- cfg_stop_inc_i  in  16  last increment of the sweep.
- cfg_step_i  in  16  increment delta per step.
- cfg_dwell_i  in  16  accepted samples per step; 0 is treated as 1.
- sample_valid_i  in  1  snoop of the sine core's tvalid.
- sample_ready_i  in  1  snoop of the downstream tready.
- stim_en_o  out  1  enable to the sine core.
- stim_inc_o  out  16  angular increment to the sine core.
- busy_o  out  1  high while in UP or DOWN.
- done_o  out  1  one-cycle pulse when a single sweep completes.

## Operation
- Handshake event: hs = sample_valid_i & sample_ready_i. Only hs advances the dwell counter; valid without ready is ignored.
- States: IDLE, UP, DOWN, DONE.
- IDLE:
  - Outputs: stim_en_o=0, busy_o=0.
  - When cfg_en_i=1: latch start, stop, step, dwell and mode into internal registers; set stim_inc_o=start and dwell_cnt=0; go to UP.
  - Configuration changes outside IDLE are ignored.
- UP and DOWN:
  - Outputs: stim_en_o=1, busy_o=1.
  - On hs: if dwell_cnt < dwell_eff-1, increment dwell_cnt. Otherwise clear dwell_cnt and take a step (rules below).
  - dwell_eff = max(dwell, 1).
- Step in UP:
  - If inc ≥ stop, this is end of leg:
    - single: go to DONE.
    - repeat: inc ← start, stay in UP.
    - triangle: go to DOWN, inc ← max(stop − step, start).
  - Otherwise inc ← min(inc + step, stop). Compute the sum at 17 bits so a carry also clamps to stop.
- Step in DOWN:
  - If inc ≤ start: go to UP, inc ← min(start + step, stop).
  - Otherwise inc ← max(inc − step, start). Compute the difference at 17 bits so a borrow also clamps to start.
- Degenerate configurations:
  - start > stop: the sweep holds at start. Every step is end of leg, and inc is reloaded to start.
  - step = 0: inc never changes. The sweep ends only if start == stop; otherwise it runs until disabled.
- DONE:
  - Outputs: stim_en_o=0, busy_o=0; stim_inc_o holds stop.
  - done_o pulses for one cycle on entry.
  - Returns to IDLE when cfg_en_i=0. No restart happens until cfg_en_i has been seen low.
- cfg_en_i=0 in UP or DOWN: go to IDLE on the next edge. stim_en_o drops and no done_o pulse is produced.
- The new increment takes effect from the sine core's phase advance for the next accepted sample. The sample whose hs causes a step still advances phase with the old increment.

## Timing
- Reset values: stim_en_o=0, stim_inc_o=0, busy_o=0, done_o=0, state IDLE, dwell_cnt=0.
- Reset asserted mid-sweep forces these values immediately; the sweep does not resume after release.
- All outputs are registered.
- Start latency: cfg_en_i sampled high in IDLE at edge N → stim_en_o=1 and stim_inc_o=start after edge N.
- Step latency: the last hs of a dwell at edge N → new stim_inc_o visible after edge N.
- Single-mode end: the final hs at edge N → DONE after edge N. done_o is high for exactly the cycle after edge N, and stim_en_o is low in that same cycle.
- Simultaneous hs and cfg_en_i=0 in UP or DOWN: the disable wins, and the state goes to IDLE with no step taken.
- One step at most per cycle; hs is only counted in UP and DOWN.

## Test plan
- Single sweep: start=100, stop=400, step=100, dwell=2, hs every cycle → stim_inc_o per hs is 100,100,200,200,300,300,400,400. Then done_o pulses once, stim_en_o=0, stim_inc_o stays 400.
- Clamp: start=0, stop=250, step=100, dwell=1, single → 0,100,200,250, then DONE. A separate case with start=0xFF00, stop=0xFFF0, step=0x0200 → 0xFF00, 0xFFF0 (carry clamped).
- Triangle: start=10, stop=30, step=10, dwell=1 → 10,20,30,20,10,20,30,… busy_o stays high throughout; done_o never asserts.
- Repeat with backpressure: start=5, stop=15, step=5, dwell=3. Hold ready low for 4 cycles while valid is high → no dwell progress during the stall. The sequence is 5×3, 10×3, 15×3, then back to 5.
- Dwell=0 and step=0: dwell=0 behaves as dwell=1. With step=0 and start≠stop, inc stays at start indefinitely with no DONE; with step=0 and start==stop=7, single mode reaches DONE after 1 hs.
- Abort and reset: drop cfg_en_i mid-sweep, including on an hs cycle → IDLE next cycle, stim_en_o=0, no done_o. Assert rst_n low mid-sweep → all outputs 0 immediately. Change cfg_* during a sweep → no effect until the next start.
